// File: rtl/iter_seq_ctrl.sv
// iter_seq_ctrl: sequences ITERS steps of an iterative datapath op.
// Ports: clk, rst_b (async, active-low); start/abort requests; cnt_q
//   counter readback; cnt_clear/cnt_up drive the counter; load_en and
//   step_en strobe the datapath; ready/busy/done handshake outward.
module iter_seq_ctrl #(
    parameter int                WIDTH    = 8,
    parameter logic [WIDTH-1:0]  CNT_INIT = 8'hff,
    parameter int unsigned       ITERS    = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_clear,
    output logic             cnt_up,
    output logic             load_en,
    output logic             step_en,
    output logic             ready,
    output logic             busy,
    output logic             done
);

    // Terminal count wraps modulo 2^WIDTH; ITERS = 2^WIDTH yields
    // END_VAL = CNT_INIT, reached only after a full wrap.
    localparam logic [WIDTH-1:0] END_VAL = CNT_INIT + WIDTH'(ITERS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_STEP,
        S_CHECK,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nx;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Abort outranks every transition out of a busy state,
    // including the completion match in CHECK.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start) state_nx = S_INIT;
            end
            S_INIT: begin
                state_nx = abort ? S_IDLE : S_STEP;
            end
            S_STEP: begin
                state_nx = abort ? S_IDLE : S_CHECK;
            end
            S_CHECK: begin
                if (abort)
                    state_nx = S_IDLE;
                else if (cnt_q == END_VAL)
                    state_nx = S_DONE;
                else
                    state_nx = S_STEP;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Moore decode: reset forces IDLE, so strobes drop asynchronously.
    always_comb begin
        cnt_clear = 1'b0;
        cnt_up    = 1'b0;
        load_en   = 1'b0;
        step_en   = 1'b0;
        ready     = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
            end
            S_INIT: begin
                cnt_clear = 1'b1;
                load_en   = 1'b1;
            end
            S_STEP: begin
                cnt_up  = 1'b1;
                step_en = 1'b1;
            end
            S_CHECK: begin
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                ready = 1'b1;
                busy  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_iter_seq_ctrl.sv
// tb_iter_seq_ctrl: three configurations (default, ITERS=1, 4-bit wrap)
// run against a cycle-position model with an attached counter model.
module tb_iter_seq_ctrl;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;

    int total = 0;
    int bad = 0;

    // {ready,busy,done,cnt_clear,cnt_up,load_en,step_en}
    logic [6:0] ov0, ov1, ov2;
    logic [7:0] cnt0, cnt1;
    logic [3:0] cnt2;

    always #5 clk = ~clk;

    iter_seq_ctrl u0 (
        .clk(clk), .rst_b(rst_b), .start(start), .abort(abort),
        .cnt_q(cnt0),
        .ready(ov0[6]), .busy(ov0[5]), .done(ov0[4]),
        .cnt_clear(ov0[3]), .cnt_up(ov0[2]),
        .load_en(ov0[1]), .step_en(ov0[0])
    );

    iter_seq_ctrl #(.WIDTH(8), .CNT_INIT(8'hff), .ITERS(1)) u1 (
        .clk(clk), .rst_b(rst_b), .start(start), .abort(abort),
        .cnt_q(cnt1),
        .ready(ov1[6]), .busy(ov1[5]), .done(ov1[4]),
        .cnt_clear(ov1[3]), .cnt_up(ov1[2]),
        .load_en(ov1[1]), .step_en(ov1[0])
    );

    iter_seq_ctrl #(.WIDTH(4), .CNT_INIT(4'hf), .ITERS(16)) u2 (
        .clk(clk), .rst_b(rst_b), .start(start), .abort(abort),
        .cnt_q(cnt2),
        .ready(ov2[6]), .busy(ov2[5]), .done(ov2[4]),
        .cnt_clear(ov2[3]), .cnt_up(ov2[2]),
        .load_en(ov2[1]), .step_en(ov2[0])
    );

    // Attached up-counters (environment, not expectation).
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt0 <= 8'hff;
            cnt1 <= 8'hff;
            cnt2 <= 4'hf;
        end else begin
            if (ov0[3]) cnt0 <= 8'hff;
            else if (ov0[2]) cnt0 <= cnt0 + 8'd1;
            if (ov1[3]) cnt1 <= 8'hff;
            else if (ov1[2]) cnt1 <= cnt1 + 8'd1;
            if (ov2[3]) cnt2 <= 4'hf;
            else if (ov2[2]) cnt2 <= cnt2 + 4'd1;
        end
    end

    // Model: t = cycle number within an operation (0 = idle).
    int t0 = 0, t1 = 0, t2 = 0;

    function automatic int next_t(int t, int it, logic s, logic a);
        if (t == 0) return s ? 1 : 0;
        if (a) return 0;
        if (t == 2 * it + 2) return 0;
        return t + 1;
    endfunction

    function automatic logic [6:0] exp_of(int t, int it);
        if (t == 0) return 7'b1000000;
        if (t == 1) return 7'b0101010;
        if (t == 2 * it + 2) return 7'b0110000;
        if (t % 2 == 0) return 7'b0100101;
        return 7'b0100000;
    endfunction

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            t0 <= 0;
            t1 <= 0;
            t2 <= 0;
        end else begin
            t0 <= next_t(t0, 8, start, abort);
            t1 <= next_t(t1, 1, start, abort);
            t2 <= next_t(t2, 16, start, abort);
        end
    end

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        chk("u0_out", int'(ov0), int'(exp_of(t0, 8)));
        chk("u1_out", int'(ov1), int'(exp_of(t1, 1)));
        chk("u2_out", int'(ov2), int'(exp_of(t2, 16)));
        if (t0 == 18) chk("u0_end", int'(cnt0), 'h07);
        if (t1 == 4) chk("u1_end", int'(cnt1), 'h00);
        if (t2 == 34) chk("u2_end", int'(cnt2), 'hf);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Single start pulse; records done cycle and step counts.
    task automatic run_nom(input bit poke, input string tag);
        int d0, d1, d2, s0, s1, s2;
        d0 = 0; d1 = 0; d2 = 0;
        s0 = 0; s1 = 0; s2 = 0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 1) chk({tag, "_clr"}, int'(ov0[3]), 1);
            if (ov0[4] && d0 == 0) d0 = k;
            if (ov1[4] && d1 == 0) d1 = k;
            if (ov2[4] && d2 == 0) d2 = k;
            s0 += int'(ov0[0]);
            s1 += int'(ov1[0]);
            s2 += int'(ov2[0]);
            start = poke && (k == 4);
            cyc();
        end
        start = 1'b0;
        chk({tag, "_lat0"}, d0, 18);
        chk({tag, "_lat1"}, d1, 4);
        chk({tag, "_lat2"}, d2, 34);
        chk({tag, "_st0"}, s0, 8);
        chk({tag, "_st1"}, s1, 1);
        chk({tag, "_st2"}, s2, 16);
    endtask

    initial begin
        int sc, dc, cc;
        // Reset held with start high.
        start = 1'b1;
        #1;
        cyc();
        cyc();
        chk("rst_out", int'(ov0), 'h40);
        chk("rst_out2", int'(ov2), 'h40);
        start = 1'b0;
        rst_b = 1'b1;
        cyc();
        chk("post_rst", int'(ov0[6]), 1);

        run_nom(1'b0, "nom");

        // Abort on the 3rd CHECK (cycle 7).
        start = 1'b1;
        cyc();
        start = 1'b0;
        sc = 0;
        dc = 0;
        for (int k = 1; k <= 20; k++) begin
            sc += int'(ov0[0]);
            dc += int'(ov0[4]);
            if (k == 8) chk("abort_idle", int'(ov0[6]), 1);
            abort = (k == 7);
            cyc();
        end
        abort = 1'b0;
        chk("abort_steps", sc, 3);
        chk("abort_done", dc, 0);
        run_nom(1'b0, "rerun");

        // start poked during STEP is ignored.
        run_nom(1'b1, "poke");

        // Held start: back-to-back ops every 19 cycles.
        start = 1'b1;
        cyc();
        dc = 0;
        cc = 0;
        for (int k = 1; k <= 57; k++) begin
            dc += int'(ov0[4]);
            cc += int'(ov0[3]);
            cyc();
        end
        start = 1'b0;
        chk("held_done", dc, 3);
        chk("held_clr", cc, 3);
        repeat (40) cyc();

        // Async reset in the middle of a STEP cycle.
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        chk("pre_ar_step", int'(ov0[0]), 1);
        #2;
        rst_b = 1'b0;
        #1;
        chk("ar_up", int'(ov0[2]), 0);
        chk("ar_step", int'(ov0[0]), 0);
        chk("ar_busy", int'(ov0[5]), 0);
        cyc();
        #2;
        rst_b = 1'b1;
        cyc();
        run_nom(1'b0, "post_ar");

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            start = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 15) == 0);
            cyc();
        end
        start = 1'b0;
        abort = 1'b0;
        repeat (40) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
